// File: rtl/tx_framed.sv
// -----------------------------------------------------------------------------
// tx_framed
// Buffered asynchronous serial transmitter. Words are written into a small
// FIFO and then shifted out as frames: a start bit (0), DATA_SIZE data bits
// LSB first, an optional parity bit, and STOP_BITS stop bits (1). When the
// FIFO still holds words as a frame ends, the next frame starts with no idle
// time in between.
//
// Parameters
//   CLK_BAUD_RATIO : clock cycles per serial bit (>= 2)
//   DATA_SIZE      : data bits per frame (1..16)
//   PARITY_MODE    : 0 none, 1 even, 2 odd
//   STOP_BITS      : stop bits per frame (1 or 2)
//   FIFO_DEPTH     : word-buffer entries (power of 2, >= 2)
//
// Ports
//   clk_in      : clock, all logic on its rising edge
//   rst_in      : asynchronous active-high reset
//   new_data_in : write strobe for data_in
//   data_in     : word to transmit
//   ready_out   : high when the FIFO can accept a word
//   tx_out      : serial line, idle high
//   busy_out    : high while a frame is shifting or the FIFO is non-empty
//   count_out   : number of words held in the FIFO
// -----------------------------------------------------------------------------
module tx_framed #(
  parameter int CLK_BAUD_RATIO = 868,
  parameter int DATA_SIZE      = 8,
  parameter int PARITY_MODE    = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          new_data_in,
  input  logic [DATA_SIZE-1:0]          data_in,
  output logic                          ready_out,
  output logic                          tx_out,
  output logic                          busy_out,
  output logic [$clog2(FIFO_DEPTH):0]   count_out
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLK_BAUD_RATIO > 2) ? $clog2(CLK_BAUD_RATIO) : 1;
  localparam int NW = 5;  // covers up to 16 data bits and 2 stop bits

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  // ---------------------------------------------------------------------------
  // Word FIFO
  // ---------------------------------------------------------------------------
  logic [DATA_SIZE-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_reg;
  logic [PW-1:0]        rd_ptr_reg;
  logic [CW-1:0]        count_reg;
  logic                 push;
  logic                 pop;
  logic [DATA_SIZE-1:0] head;

  // ready is based on the occupancy before any pop on the same edge, so a
  // full FIFO refuses a write even while the shifter is draining it.
  assign ready_out = (count_reg != CW'(FIFO_DEPTH));
  assign push      = new_data_in && ready_out;
  assign head      = mem[rd_ptr_reg];

  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  // Pointers are exactly PW bits wide, so they wrap modulo FIFO_DEPTH.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame shifter
  // ---------------------------------------------------------------------------
  state_t               state_reg,  state_next;
  logic [BW-1:0]        baud_reg,   baud_next;
  logic [NW-1:0]        bit_reg,    bit_next;
  logic [DATA_SIZE-1:0] shift_reg,  shift_next;
  logic                 parity_reg, parity_next;
  logic                 tx_reg,     tx_next;

  logic                 tick;
  logic [DATA_SIZE-1:0] shifted;
  logic                 head_parity;

  // tick marks the last clock of the current bit; the counter reloads to
  // zero there so every bit lasts exactly CLK_BAUD_RATIO clocks.
  assign tick        = (baud_reg == BW'(CLK_BAUD_RATIO - 1));
  assign shifted     = shift_reg >> 1;
  assign head_parity = (^head) ^ (PARITY_MODE == 2);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg  <= IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      tx_reg     <= 1'b1;
    end else begin
      state_reg  <= state_next;
      baud_reg   <= baud_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      tx_reg     <= tx_next;
    end
  end

  // tx is registered: the comb block chooses the level for the next bit at
  // the boundary where that bit begins, so the line changes on that edge.
  always_comb begin
    state_next  = state_reg;
    baud_next   = tick ? '0 : baud_reg + 1'b1;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    tx_next     = tx_reg;
    pop         = 1'b0;

    case (state_reg)
      IDLE: begin
        baud_next = '0;
        tx_next   = 1'b1;
        if (count_reg != '0) begin
          pop         = 1'b1;
          shift_next  = head;
          parity_next = head_parity;
          bit_next    = '0;
          state_next  = START;
          tx_next     = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_next = DATA;
          bit_next   = '0;
          tx_next    = shift_reg[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_reg == NW'(DATA_SIZE - 1)) begin
            bit_next = '0;
            if (PARITY_MODE != 0) begin
              state_next = PARITY;
              tx_next    = parity_reg;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next   = bit_reg + 1'b1;
            shift_next = shifted;
            tx_next    = shifted[0];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_next = STOP;
          bit_next   = '0;
          tx_next    = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_reg == NW'(STOP_BITS - 1)) begin
            bit_next = '0;
            // Chain straight into the next start bit when a word is waiting.
            if (count_reg != '0) begin
              pop         = 1'b1;
              shift_next  = head;
              parity_next = head_parity;
              state_next  = START;
              tx_next     = 1'b0;
            end else begin
              state_next = IDLE;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  assign tx_out    = tx_reg;
  assign busy_out  = (state_reg != IDLE) || (count_reg != '0);
  assign count_out = count_reg;

endmodule

// File: tb/tb_tx_framed.sv
// -----------------------------------------------------------------------------
// tb_tx_framed
// Four tx_framed instances share one clock and reset:
//   0: no parity, 1 stop   1: even parity   2: odd parity   3: 2 stop bits
// All use CLK_BAUD_RATIO=2, DATA_SIZE=4, FIFO_DEPTH=4.
// A cycle model tracks FIFO occupancy and frame progress; each accepted word
// appends its expected per-cycle line levels to a scoreboard queue, which is
// consumed one entry per clock while the model says a frame is on the line.
// -----------------------------------------------------------------------------
module tb_tx_framed;

  logic       clk;
  logic       rst;
  logic       nd   [4];
  logic [3:0] din  [4];
  logic       rdy  [4];
  logic       txo  [4];
  logic       bsy  [4];
  logic [2:0] cnt  [4];

  int n_cmp;
  int n_fail;

  // model state
  int   m_count;
  int   m_rem;
  bit   exp_q[$];
  logic exp_tx;
  logic exp_busy;
  logic exp_rdy;
  logic [2:0] exp_cnt;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      tx_framed #(
        .CLK_BAUD_RATIO(2),
        .DATA_SIZE(4),
        .PARITY_MODE(gi == 1 ? 1 : (gi == 2 ? 2 : 0)),
        .STOP_BITS(gi == 3 ? 2 : 1),
        .FIFO_DEPTH(4)
      ) u_dut (
        .clk_in(clk),
        .rst_in(rst),
        .new_data_in(nd[gi]),
        .data_in(din[gi]),
        .ready_out(rdy[gi]),
        .tx_out(txo[gi]),
        .busy_out(bsy[gi]),
        .count_out(cnt[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int par_mode(input int idx);
    return (idx == 1) ? 1 : ((idx == 2) ? 2 : 0);
  endfunction

  function automatic int stop_bits(input int idx);
    return (idx == 3) ? 2 : 1;
  endfunction

  function automatic int frame_len(input int idx);
    return 2 * (1 + 4 + ((par_mode(idx) != 0) ? 1 : 0) + stop_bits(idx));
  endfunction

  // Expected line levels of one frame, each bit held for two clocks.
  function automatic void queue_frame(input int idx, input logic [3:0] w);
    bit b;
    exp_q.push_back(1'b0); exp_q.push_back(1'b0);
    for (int i = 0; i < 4; i++) begin
      b = w[i];
      exp_q.push_back(b); exp_q.push_back(b);
    end
    if (par_mode(idx) != 0) begin
      b = (w[0] ^ w[1] ^ w[2] ^ w[3]) ^ (par_mode(idx) == 2);
      exp_q.push_back(b); exp_q.push_back(b);
    end
    for (int i = 0; i < 2 * stop_bits(idx); i++) exp_q.push_back(1'b1);
  endfunction

  task automatic model_reset();
    m_count  = 0;
    m_rem    = 0;
    exp_q.delete();
    exp_tx   = 1'b1;
    exp_busy = 1'b0;
    exp_rdy  = 1'b1;
    exp_cnt  = 3'd0;
  endtask

  // Called at a falling edge: drives inputs, advances one rising edge,
  // updates the model, and returns at the next falling edge.
  task automatic step(input int idx, input logic n, input logic [3:0] d);
    bit push_ok;
    bit pop_ok;
    nd[idx]  = n;
    din[idx] = d;
    @(posedge clk);
    push_ok = n && (m_count != 4);
    pop_ok  = (m_rem <= 1) && (m_count > 0);
    if (m_rem > 1)   m_rem = m_rem - 1;
    else if (pop_ok) m_rem = frame_len(idx);
    else             m_rem = 0;
    m_count = m_count + (push_ok ? 1 : 0) - (pop_ok ? 1 : 0);
    if (push_ok) queue_frame(idx, d);
    if (m_rem > 0) exp_tx = exp_q.pop_front();
    else           exp_tx = 1'b1;
    exp_busy = (m_rem > 0) || (m_count > 0);
    exp_rdy  = (m_count != 4);
    exp_cnt  = 3'(m_count);
    @(negedge clk);
    nd[idx]  = 1'b0;
    din[idx] = 4'($urandom_range(0, 15));  // later data_in changes must not matter
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (txo[i] !== 1'b1) begin n_fail++; $display("FAIL reset_tx dut%0d: got %b exp 1", i, txo[i]); end
      n_cmp++; if (bsy[i] !== 1'b0) begin n_fail++; $display("FAIL reset_busy dut%0d: got %b exp 0", i, bsy[i]); end
      n_cmp++; if (rdy[i] !== 1'b1) begin n_fail++; $display("FAIL reset_ready dut%0d: got %b exp 1", i, rdy[i]); end
      n_cmp++; if (cnt[i] !== 3'd0) begin n_fail++; $display("FAIL reset_count dut%0d: got %0d exp 0", i, cnt[i]); end
    end
    $display("test_reset: %0d compared", n_cmp);
  endtask

  task automatic test_single(input int idx, input logic [3:0] w);
    do_reset();
    for (int c = 0; c < frame_len(idx) + 5; c++) begin
      if (c == 0) step(idx, 1'b1, w);
      else        step(idx, 1'b0, 4'h0);
      n_cmp++; if (txo[idx] !== exp_tx)   begin n_fail++; $display("FAIL single%0d tx cyc%0d: got %b exp %b", idx, c, txo[idx], exp_tx); end
      n_cmp++; if (bsy[idx] !== exp_busy) begin n_fail++; $display("FAIL single%0d busy cyc%0d: got %b exp %b", idx, c, bsy[idx], exp_busy); end
      n_cmp++; if (cnt[idx] !== exp_cnt)  begin n_fail++; $display("FAIL single%0d count cyc%0d: got %0d exp %0d", idx, c, cnt[idx], exp_cnt); end
    end
    $display("test_single dut%0d word %h: %0d compared, %0d mismatched so far", idx, w, n_cmp, n_fail);
  endtask

  task automatic test_fifo_full();
    logic [3:0] words [6];
    words = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      step(0, 1'b1, words[c]);
      n_cmp++; if (cnt[0] !== exp_cnt)   begin n_fail++; $display("FAIL fill count push%0d: got %0d exp %0d", c, cnt[0], exp_cnt); end
      n_cmp++; if (rdy[0] !== exp_rdy)   begin n_fail++; $display("FAIL fill ready push%0d: got %b exp %b", c, rdy[0], exp_rdy); end
      n_cmp++; if (txo[0] !== exp_tx)    begin n_fail++; $display("FAIL fill tx push%0d: got %b exp %b", c, txo[0], exp_tx); end
    end
    n_cmp++; if (cnt[0] !== 3'd4) begin n_fail++; $display("FAIL fill full_count: got %0d exp 4", cnt[0]); end
    for (int c = 0; c < 5 * frame_len(0) + 5; c++) begin
      step(0, 1'b0, 4'h0);
      n_cmp++; if (txo[0] !== exp_tx)   begin n_fail++; $display("FAIL fill tx cyc%0d: got %b exp %b", c, txo[0], exp_tx); end
      n_cmp++; if (bsy[0] !== exp_busy) begin n_fail++; $display("FAIL fill busy cyc%0d: got %b exp %b", c, bsy[0], exp_busy); end
      n_cmp++; if (cnt[0] !== exp_cnt)  begin n_fail++; $display("FAIL fill count cyc%0d: got %0d exp %0d", c, cnt[0], exp_cnt); end
    end
    $display("test_fifo_full: %0d compared, %0d mismatched so far", n_cmp, n_fail);
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 2 * frame_len(3) + 6; c++) begin
      if (c == 0)      step(3, 1'b1, 4'hA);
      else if (c == 1) step(3, 1'b1, 4'h5);
      else             step(3, 1'b0, 4'h0);
      n_cmp++; if (txo[3] !== exp_tx)   begin n_fail++; $display("FAIL b2b tx cyc%0d: got %b exp %b", c, txo[3], exp_tx); end
      n_cmp++; if (bsy[3] !== exp_busy) begin n_fail++; $display("FAIL b2b busy cyc%0d: got %b exp %b", c, bsy[3], exp_busy); end
    end
    $display("test_back_to_back: %0d compared, %0d mismatched so far", n_cmp, n_fail);
  endtask

  task automatic test_full_pop_push();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step(0, 1'b1, 4'(c + 1));
      n_cmp++; if (cnt[0] !== exp_cnt) begin n_fail++; $display("FAIL popfull count push%0d: got %0d exp %0d", c, cnt[0], exp_cnt); end
    end
    // run until the next edge is the one that pops from the full FIFO
    for (int g = 0; g < 200 && !(m_rem == 1 && m_count == 4); g++) begin
      step(0, 1'b0, 4'h0);
      n_cmp++; if (txo[0] !== exp_tx) begin n_fail++; $display("FAIL popfull tx wait%0d: got %b exp %b", g, txo[0], exp_tx); end
    end
    n_cmp++; if (rdy[0] !== 1'b0) begin n_fail++; $display("FAIL popfull ready_before: got %b exp 0", rdy[0]); end
    step(0, 1'b1, 4'h9);  // refused: FIFO full before the pop
    n_cmp++; if (cnt[0] !== 3'd3) begin n_fail++; $display("FAIL popfull refused_count: got %0d exp 3", cnt[0]); end
    n_cmp++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL popfull ready_after: got %b exp 1", rdy[0]); end
    step(0, 1'b1, 4'hC);  // accepted
    n_cmp++; if (cnt[0] !== 3'd4) begin n_fail++; $display("FAIL popfull accepted_count: got %0d exp 4", cnt[0]); end
    for (int c = 0; c < 5 * frame_len(0) + 5; c++) begin
      step(0, 1'b0, 4'h0);
      n_cmp++; if (txo[0] !== exp_tx)   begin n_fail++; $display("FAIL popfull tx cyc%0d: got %b exp %b", c, txo[0], exp_tx); end
      n_cmp++; if (bsy[0] !== exp_busy) begin n_fail++; $display("FAIL popfull busy cyc%0d: got %b exp %b", c, bsy[0], exp_busy); end
      n_cmp++; if (cnt[0] !== exp_cnt)  begin n_fail++; $display("FAIL popfull count cyc%0d: got %0d exp %0d", c, cnt[0], exp_cnt); end
    end
    $display("test_full_pop_push: %0d compared, %0d mismatched so far", n_cmp, n_fail);
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(0, 1'b1, 4'h3);  // bit 2 of this word is 0, so the abort is visible
    step(0, 1'b1, 4'hA);
    step(0, 1'b1, 4'h5);
    // frame is 12 clocks; remaining 6 means data bit 2 is on the line
    for (int g = 0; g < 50 && m_rem != 6; g++) begin
      step(0, 1'b0, 4'h0);
      n_cmp++; if (txo[0] !== exp_tx) begin n_fail++; $display("FAIL rstmid tx pre%0d: got %b exp %b", g, txo[0], exp_tx); end
    end
    n_cmp++; if (txo[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid data_bit2: got %b exp 0", txo[0]); end
    n_cmp++; if (cnt[0] !== 3'd2) begin n_fail++; $display("FAIL rstmid queued: got %0d exp 2", cnt[0]); end
    rst = 1'b1;
    #1;
    n_cmp++; if (txo[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid async_tx: got %b exp 1", txo[0]); end
    n_cmp++; if (cnt[0] !== 3'd0) begin n_fail++; $display("FAIL rstmid async_count: got %0d exp 0", cnt[0]); end
    n_cmp++; if (bsy[0] !== 1'b0) begin n_fail++; $display("FAIL rstmid async_busy: got %b exp 0", bsy[0]); end
    n_cmp++; if (rdy[0] !== 1'b1) begin n_fail++; $display("FAIL rstmid async_ready: got %b exp 1", rdy[0]); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 40; c++) begin
      step(0, 1'b0, 4'h0);
      n_cmp++; if (txo[0] !== exp_tx)   begin n_fail++; $display("FAIL rstmid tx post%0d: got %b exp %b", c, txo[0], exp_tx); end
      n_cmp++; if (bsy[0] !== exp_busy) begin n_fail++; $display("FAIL rstmid busy post%0d: got %b exp %b", c, bsy[0], exp_busy); end
    end
    $display("test_reset_mid: %0d compared, %0d mismatched so far", n_cmp, n_fail);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    for (int i = 0; i < 4; i++) begin
      nd[i]  = 1'b0;
      din[i] = 4'h0;
    end
    model_reset();
    test_reset();
    test_single(0, 4'b0110);
    test_single(1, 4'b0110);
    test_single(2, 4'b0110);
    test_single(1, 4'b0111);
    test_fifo_full();
    test_back_to_back();
    test_full_pop_push();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
